piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter SIZE_DATA_IN, default 8: parallel word width in bits.
REQ-002 Parameter SIZE_DATA_OUT, default 1: serial symbol width in bits; SIZE_DATA_IN SHALL be an integer multiple of SIZE_DATA_OUT, with DEPTH = SIZE_DATA_IN/SIZE_DATA_OUT >= 2.
REQ-003 Parameter MSB_FIRST, default 1: 1 = most-significant symbol emitted first, 0 = least-significant first.
REQ-004 i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_valid  input  1  upstream word valid.
REQ-007 i_data  input  SIZE_DATA_IN  parallel word, sampled on accept.
REQ-008 o_ready  output  1  block can accept a word this cycle.
REQ-009 o_data  output  SIZE_DATA_OUT  current serial symbol.
REQ-010 o_valid  output  1  o_data holds a valid symbol.
REQ-011 i_ready  input  1  downstream consumes the symbol this cycle.
REQ-012 o_last  output  1  current symbol is the final symbol of its word.

Function
REQ-013 Block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word being emitted).
REQ-014 Word accept SHALL occur on a rising edge where i_valid=1 and o_ready=1; i_data is captured into an internal shift register and the symbol counter is cleared to 0.
REQ-015 o_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when o_last=1 and i_ready=1; 0 otherwise.
REQ-016 i_data and i_valid SHALL be ignored on edges where o_ready=0.
REQ-017 IDLE -> SHIFT on accept; o_valid SHALL assert in the cycle after the accepting edge (latency 1 cycle from accept to first symbol).
REQ-018 In SHIFT, o_valid=1, and o_data SHALL present symbol number count of the held word: bits [SIZE_DATA_IN-1-count*SIZE_DATA_OUT -: SIZE_DATA_OUT] when MSB_FIRST=1, bits [count*SIZE_DATA_OUT +: SIZE_DATA_OUT] when MSB_FIRST=0.
REQ-019 A symbol SHALL be consumed on an edge where o_valid=1 and i_ready=1; the counter increments by 1 and the next symbol is presented.
REQ-020 With i_ready=0, o_data, o_last and the counter SHALL hold unchanged (no symbol dropped or repeated).
REQ-021 o_last SHALL be 1 exactly when o_valid=1 and count = DEPTH-1.
REQ-022 On consuming the last symbol: with a simultaneous accept, the FSM SHALL stay in SHIFT and load the new word with count=0, giving zero-bubble back-to-back words; without one, the FSM SHALL return to IDLE.
REQ-023 The counter SHALL be $clog2(DEPTH) bits wide (minimum 1) and SHALL never exceed DEPTH-1.
REQ-024 In IDLE, o_valid=0, o_last=0 and o_data=0.
REQ-025 Throughput SHALL be one symbol per cycle while i_ready=1 and words are supplied on every o_ready.

Reset
REQ-026 On i_rst_n=0, the FSM SHALL enter IDLE asynchronously, the shift register and counter SHALL clear to 0, o_valid=0, o_last=0, o_data=0 and o_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the partial word; after release, no residual symbols SHALL be emitted and the first accepted word SHALL start at symbol 0.

Verification
REQ-028 Defaults, MSB_FIRST=1, i_ready=1, accept 8'hB4 -> o_data 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting 1 cycle after accept; o_last only on the 8th; then IDLE with o_valid=0.
REQ-029 MSB_FIRST=0, accept 8'hB4 -> o_data 0,0,1,0,1,1,0,1.
REQ-030 Back-to-back: 8'hFF then 8'h00, with i_valid held high -> 16 consecutive valid symbols (eight 1s, then eight 0s); o_ready high only on the 8th symbol cycle; no gap.
REQ-031 Backpressure: accept 8'hB4, drop i_ready for 3 cycles while the 3rd symbol is shown -> o_data=1 is held 4 cycles, and the sequence otherwise matches REQ-028; i_valid with a different word during SHIFT is ignored.
REQ-032 SIZE_DATA_OUT=2, accept 8'hB4 -> o_data 2'b10, 2'b11, 2'b01, 2'b00; o_last on the 4th symbol.
REQ-033 Reset pulse after the 3rd symbol of 8'hB4 -> o_valid=0 and o_ready=1 immediately; a subsequent accept of 8'h81 emits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with valid/ready on both sides.
// A word is captured on accept and emitted one symbol per consumed cycle; the last
// symbol's consume can accept the next word for gap-free back-to-back streaming.
module piso_serializer #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 1,
  parameter int MSB_FIRST     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic                     o_ready,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);

  localparam int DEPTH = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                  state_q;
  logic [SIZE_DATA_IN-1:0] sreg_q;
  logic [SIZE_DATA_IN-1:0] sreg_shift;
  logic [CW-1:0]           count_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    accept;
  logic                    consume;

  // The outgoing symbol always sits at the emit end of the shift register, so
  // o_data is a fixed slice; the register is cleared in IDLE, which yields zero.
  always_comb begin
    sreg_shift = sreg_q;
    o_data     = '0;
    if (MSB_FIRST != 0) begin
      sreg_shift = sreg_q << SIZE_DATA_OUT;
      o_data     = sreg_q[SIZE_DATA_IN-1 -: SIZE_DATA_OUT];
    end else begin
      sreg_shift = sreg_q >> SIZE_DATA_OUT;
      o_data     = sreg_q[SIZE_DATA_OUT-1:0];
    end
  end

  // Ready when empty, or when the final symbol is leaving this very cycle.
  always_comb begin
    o_ready = (state_q == IDLE) || (last_q && i_ready);
    accept  = i_valid && o_ready;
    consume = valid_q && i_ready;
  end

  assign o_valid = valid_q;
  assign o_last  = last_q;

  // Control FSM with registered valid/last; shift register and symbol counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SHIFT;
            sreg_q  <= i_data;
            count_q <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (consume) begin
            if (last_q) begin
              if (accept) begin
                sreg_q  <= i_data;
                count_q <= '0;
                valid_q <= 1'b1;
                last_q  <= 1'b0;
              end else begin
                state_q <= IDLE;
                sreg_q  <= '0;
                count_q <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              sreg_q  <= sreg_shift;
              count_q <= count_q + CW'(1);
              last_q  <= ((count_q + CW'(1)) == LAST_CNT);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first x1, LSB-first x1,
// MSB-first x2) each checked every cycle against a remaining-symbol-count model.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       iv [3];
  logic       ir [3];
  logic [7:0] id [3];
  logic       ov [3];
  logic       ol [3];
  logic       ordy [3];
  logic [1:0] od [3];

  logic       d0_data;
  logic       d1_data;
  logic [1:0] d2_data;

  int vectors;
  int miscompares;

  // Reference model state: current word and number of its symbols not yet consumed.
  logic [7:0] m_word [3];
  int         m_rem  [3];
  int         sw     [3];
  int         msb    [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_serializer #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1), .MSB_FIRST(1)) u_msb1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[0]), .i_data(id[0]), .o_ready(ordy[0]),
    .o_data(d0_data), .o_valid(ov[0]), .i_ready(ir[0]), .o_last(ol[0]));

  piso_serializer #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1), .MSB_FIRST(0)) u_lsb1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[1]), .i_data(id[1]), .o_ready(ordy[1]),
    .o_data(d1_data), .o_valid(ov[1]), .i_ready(ir[1]), .o_last(ol[1]));

  piso_serializer #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2), .MSB_FIRST(1)) u_msb2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[2]), .i_data(id[2]), .o_ready(ordy[2]),
    .o_data(d2_data), .o_valid(ov[2]), .i_ready(ir[2]), .o_last(ol[2]));

  assign od[0] = {1'b0, d0_data};
  assign od[1] = {1'b0, d1_data};
  assign od[2] = d2_data;

  function automatic logic [1:0] sym(logic [7:0] w, int idx, int width, int msbf);
    int sh;
    logic [7:0] t;
    sh = (msbf != 0) ? 8 - (idx + 1) * width : idx * width;
    t  = w >> sh;
    return (width == 2) ? t[1:0] : {1'b0, t[0]};
  endfunction

  task automatic chk(input string tag, input int d, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      int depth;
      logic ev;
      logic [1:0] ed;
      depth = 8 / sw[d];
      ev = (m_rem[d] > 0);
      ed = ev ? sym(m_word[d], depth - m_rem[d], sw[d], msb[d]) : 2'b00;
      chk("o_valid", d, {1'b0, ov[d]}, {1'b0, ev});
      chk("o_data",  d, od[d], ed);
      chk("o_last",  d, {1'b0, ol[d]}, {1'b0, (m_rem[d] == 1)});
      chk("o_ready", d, {1'b0, ordy[d]}, {1'b0, (m_rem[d] == 0) || (m_rem[d] == 1 && ir[d])});
    end
  endtask

  // Inputs are set by the caller just after a rising edge; check, advance model, clock.
  task automatic step();
    #2;
    check_all();
    for (int d = 0; d < 3; d++) begin
      logic rdy;
      rdy = (m_rem[d] == 0) || (m_rem[d] == 1 && ir[d]);
      if (m_rem[d] > 0 && ir[d]) m_rem[d]--;
      if (iv[d] && rdy) begin
        m_word[d] = id[d];
        m_rem[d]  = 8 / sw[d];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] data, input logic r);
    for (int d = 0; d < 3; d++) begin
      iv[d] = v;
      id[d] = data;
      ir[d] = r;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_rem[d]  = 0;
      m_word[d] = 8'h00;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sw[0] = 1; sw[1] = 1; sw[2] = 2;
    msb[0] = 1; msb[1] = 0; msb[2] = 1;
    model_reset();
    drive(1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;

    // Reset state
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    step();

    // Single word 8'hB4 with i_ready held high
    drive(1'b1, 8'hB4, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Back-to-back 8'hFF then 8'h00 with i_valid held high
    drive(1'b1, 8'hFF, 1'b1);
    step();
    drive(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Backpressure on the third symbol, with a competing word offered meanwhile
    drive(1'b1, 8'hB4, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();
    drive(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step();

    // Reset mid-word, then a fresh word must start from symbol 0
    drive(1'b1, 8'hB4, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    drive(1'b1, 8'h81, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d] = ($urandom_range(0, 2) != 0);
        id[d] = 8'($urandom);
        ir[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
